// File: rtl/alu_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package alu_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } muldiv_state_e;

  // True for the four divide/remainder operations
  function automatic logic is_div(input muldiv_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add
// multiply and restoring divide on magnitudes, sign fixed up at the end.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e               state_q;
  muldiv_op_e                  op_q;
  logic [CNT_WIDTH-1:0]        counter_q;
  logic [2*DATA_WIDTH-1:0]     acc_q;
  logic [DATA_WIDTH:0]         rem_q;
  logic [DATA_WIDTH-1:0]       operand_q;
  logic                        sign_a_q;
  logic                        sign_b_q;

  muldiv_op_e                  op_in;
  logic                        neg_a;
  logic                        neg_b;
  logic [DATA_WIDTH-1:0]       mag_a;
  logic [DATA_WIDTH-1:0]       mag_b;
  logic                        special;
  logic [DATA_WIDTH-1:0]       special_result;

  logic [DATA_WIDTH:0]         mul_sum;
  logic [DATA_WIDTH:0]         div_shift;
  logic [DATA_WIDTH:0]         div_trial;

  logic [2*DATA_WIDTH-1:0]     prod_fix;
  logic [DATA_WIDTH-1:0]       quo_fix;
  logic [DATA_WIDTH-1:0]       rem_fix;
  logic [DATA_WIDTH-1:0]       fix_result;

  // Request decode: operand signs, magnitudes and the divide short-circuits
  always_comb begin
    op_in          = muldiv_op_e'(Operation[2:0]);
    neg_a          = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[DATA_WIDTH-1];
    neg_b          = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[DATA_WIDTH-1];
    mag_a          = neg_a ? -SrcA : SrcA;
    mag_b          = neg_b ? -SrcB : SrcB;
    special        = 1'b0;
    special_result = '0;
    if (is_div(op_in) && (SrcB == '0)) begin
      special        = 1'b1;
      special_result = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : SrcA;
    end else if ((op_in inside {OP_DIV, OP_REM}) && (SrcA == MOST_NEG) && (SrcB == '1)) begin
      special        = 1'b1;
      special_result = (op_in == OP_DIV) ? SrcA : '0;
    end
  end

  // One iteration step: add-and-shift for multiply, trial subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    div_shift = {rem_q[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-1]};
    div_trial = div_shift - {1'b0, operand_q};
  end

  // Sign correction and half/quotient/remainder selection for the final result
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    rem_fix  = sign_a_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
    case (op_q)
      OP_MUL:                        fix_result = prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:               fix_result = quo_fix;
      default:                       fix_result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers; flush wins over accept and completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      counter_q  <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      operand_q  <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      Result     <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= op_in;
            sign_a_q  <= neg_a;
            sign_b_q  <= neg_b;
            req_ready <= 1'b0;
            if (special) begin
              Result     <= special_result;
              resp_valid <= 1'b1;
              state_q    <= DONE;
            end else begin
              counter_q <= CNT_WIDTH'(DATA_WIDTH);
              rem_q     <= '0;
              state_q   <= CALC;
              if (is_div(op_in)) begin
                acc_q     <= {{DATA_WIDTH{1'b0}}, mag_a};
                operand_q <= mag_b;
              end else begin
                acc_q     <= {{DATA_WIDTH{1'b0}}, mag_b};
                operand_q <= mag_a;
              end
            end
          end
        end
        CALC: begin
          counter_q <= counter_q - CNT_WIDTH'(1);
          if (is_div(op_q)) begin
            if (!div_trial[DATA_WIDTH]) begin
              rem_q <= div_trial;
              acc_q <= {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= div_shift;
              acc_q <= {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {mul_sum, acc_q[DATA_WIDTH-1:1]};
          end
          if (counter_q == CNT_WIDTH'(1)) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          Result     <= fix_result;
          resp_valid <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
